// File: rtl/sinc_pkg.sv
// Shared definitions for the SINC output skid stage.
// State encoding and signed range helpers.
package sinc_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic int smax(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int smin(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/sinc_slot.sv
// One buffer entry: load-enabled register with synchronous
// active-low clear.
module sinc_slot #(
   parameter int W = 9
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         slot_q <= '0;
      end else if (ld_i) begin
         slot_q <= d_i;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/sinc_skid_reg.sv
// Registered two-entry skid stage after the signed incrementer;
// flags MAX+1 wrap, optionally saturates, counts overflows.
module sinc_skid_reg
   import sinc_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int SATURATE  = 0,
   parameter int CNT_W     = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] in_src,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     ovf_count
);

   localparam int SW = DATAWIDTH + 1;
   localparam logic [DATAWIDTH-1:0] MAXV =
      DATAWIDTH'(smax(DATAWIDTH));

   state_t state_q, state_d;
   logic accept, emit, ovf;
   logic main_ld, skid_ld, from_skid;
   logic [DATAWIDTH-1:0] val;
   logic [SW-1:0] item, main_d, main_q, skid_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   assign ovf  = (in_src == MAXV);
   assign val  = ((SATURATE != 0) && ovf) ? MAXV : in_data;
   assign item = {ovf, val};

   always_comb begin
      state_d   = state_q;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
      from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               main_ld = 1'b1;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && emit) begin
               main_ld = 1'b1;
            end else if (accept) begin
               skid_ld = 1'b1;
               state_d = FULL;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (emit) begin
               main_ld   = 1'b1;
               from_skid = 1'b1;
               state_d   = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign main_d = from_skid ? skid_q : item;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   sinc_slot #(.W(SW)) u_main (
      .Clk  (Clk),
      .Rst  (Rst),
      .ld_i (main_ld),
      .d_i  (main_d),
      .q_o  (main_q)
   );

   sinc_slot #(.W(SW)) u_skid (
      .Clk  (Clk),
      .Rst  (Rst),
      .ld_i (skid_ld),
      .d_i  (item),
      .q_o  (skid_q)
   );

   // Counter sticks at all-ones rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && ovf && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_data  = main_q[DATAWIDTH-1:0];
   assign out_ovf   = main_q[DATAWIDTH];
   assign ovf_count = cnt_q;

endmodule
